// File: rtl/multi_cycle_ctr.sv
// Main control FSM for the multi-cycle MIPS datapath (lw, sw, R-type, beq, j).
// Moore outputs decoded from the state register, except the fetch strobes, which follow memReady.
module multi_cycle_ctr #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       illegalOp,
  output logic [3:0] state
);

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RTYPEWB = 4'd7,
    BEQ     = 4'd8,
    JUMP    = 4'd9
  } stateT;

  stateT curState;
  stateT nextState;
  logic  ready;

  assign ready = MEM_WAIT_EN ? memReady : 1'b1;
  assign state = curState;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) curState <= FETCH;
    else       curState <= nextState;
  end

  // NOTE: every output is defaulted before the case so no path leaves a latch behind.
  always_comb begin
    nextState   = FETCH;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    pcSource    = 2'b00;
    illegalOp   = 1'b0;

    case (curState)
      FETCH: begin
        memRead   = 1'b1;
        aluSrcB   = 2'b01;
        irWrite   = ready;
        pcWrite   = ready;
        nextState = ready ? DECODE : FETCH;
      end
      DECODE: begin
        aluSrcB = 2'b11;
        case (opCode)
          OpLw, OpSw: nextState = MEMADR;
          OpRtype:    nextState = EXEC;
          OpBeq:      nextState = BEQ;
          OpJ:        nextState = JUMP;
          default:    illegalOp = 1'b1;
        endcase
      end
      MEMADR: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        nextState = (opCode == OpSw) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        memRead   = 1'b1;
        iorD      = 1'b1;
        nextState = ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memToReg = 1'b1;
        regWrite = 1'b1;
      end
      MEMWR: begin
        memWrite  = 1'b1;
        iorD      = 1'b1;
        nextState = ready ? FETCH : MEMWR;
      end
      EXEC: begin
        aluSrcA   = 1'b1;
        aluOp     = 2'b10;
        nextState = RTYPEWB;
      end
      RTYPEWB: begin
        regDst   = 1'b1;
        regWrite = 1'b1;
      end
      BEQ: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
      end
      JUMP: begin
        pcWrite  = 1'b1;
        pcSource = 2'b10;
      end
      default: nextState = FETCH;
    endcase

    // Suppress all side effects while reset is held, whatever state the register holds.
    if (reset) begin
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      memToReg    = 1'b0;
      regDst      = 1'b0;
      regWrite    = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = 2'b00;
      aluOp       = 2'b00;
      pcSource    = 2'b00;
      illegalOp   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctr.sv
// Randomized bench for multi_cycle_ctr: each instruction is expanded into its expected
// per-cycle state/control trace from the instruction class and the memory wait counts.
module tb_multi_cycle_ctr;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       illegalOp;
  } ctrlT;

  typedef struct {
    int st;
    bit rdy;
  } stepT;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4;
  localparam int S_MEMWR = 5, S_EXEC = 6, S_RTYPEWB = 7, S_BEQ = 8, S_JUMP = 9;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       memReady = 1'b0;
  logic [5:0] opCode = 6'd0;
  logic       rst0 = 1'b1;
  logic [5:0] op0 = OP_LW;

  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg;
  logic       regDst, regWrite, aluSrcA, illegalOp;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] state;

  logic       pcWrite0, pcWriteCond0, iorD0, memRead0, memWrite0, irWrite0, memToReg0;
  logic       regDst0, regWrite0, aluSrcA0, illegalOp0;
  logic [1:0] aluSrcB0, aluOp0, pcSource0;
  logic [3:0] state0;

  ctrlT got, got0;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  multi_cycle_ctr dut (
    .clk(clk), .reset(reset), .opCode(opCode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
    .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSource(pcSource), .illegalOp(illegalOp), .state(state)
  );

  // Second instance ignores the handshake: memReady is tied low.
  multi_cycle_ctr #(.MEM_WAIT_EN(1'b0)) dutNoWait (
    .clk(clk), .reset(rst0), .opCode(op0), .memReady(1'b0),
    .pcWrite(pcWrite0), .pcWriteCond(pcWriteCond0), .iorD(iorD0), .memRead(memRead0),
    .memWrite(memWrite0), .irWrite(irWrite0), .memToReg(memToReg0), .regDst(regDst0),
    .regWrite(regWrite0), .aluSrcA(aluSrcA0), .aluSrcB(aluSrcB0), .aluOp(aluOp0),
    .pcSource(pcSource0), .illegalOp(illegalOp0), .state(state0)
  );

  assign got  = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                 regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp};
  assign got0 = {pcWrite0, pcWriteCond0, iorD0, memRead0, memWrite0, irWrite0, memToReg0,
                 regDst0, regWrite0, aluSrcA0, aluSrcB0, aluOp0, pcSource0, illegalOp0};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Control word each state must present, straight from the per-state output table.
  function automatic ctrlT expOut(input int st, input bit rdy, input logic [5:0] op);
    ctrlT c = '0;
    case (st)
      S_FETCH:   begin c.memRead = 1'b1; c.aluSrcB = 2'b01; c.irWrite = rdy; c.pcWrite = rdy; end
      S_DECODE:  begin
        c.aluSrcB   = 2'b11;
        c.illegalOp = !(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J});
      end
      S_MEMADR:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      S_MEMRD:   begin c.memRead = 1'b1; c.iorD = 1'b1; end
      S_MEMWB:   begin c.memToReg = 1'b1; c.regWrite = 1'b1; end
      S_MEMWR:   begin c.memWrite = 1'b1; c.iorD = 1'b1; end
      S_EXEC:    begin c.aluSrcA = 1'b1; c.aluOp = 2'b10; end
      S_RTYPEWB: begin c.regDst = 1'b1; c.regWrite = 1'b1; end
      S_BEQ:     begin c.aluSrcA = 1'b1; c.aluOp = 2'b01; c.pcWriteCond = 1'b1; c.pcSource = 2'b01; end
      S_JUMP:    begin c.pcWrite = 1'b1; c.pcSource = 2'b10; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  // One clock: drive memReady (random where it must be ignored), check mid-cycle, advance.
  task automatic applyCycle(input int st, input bit rdy, input logic [5:0] op, input bit inReset);
    ctrlT e;
    if (st == S_FETCH || st == S_MEMRD || st == S_MEMWR) memReady = rdy;
    else memReady = 1'($urandom);
    e = inReset ? ctrlT'('0) : expOut(st, rdy, op);
    @(negedge clk);
    check($sformatf("state op=%b", op), 32'(state), 32'(st));
    check($sformatf("ctrl st=%0d op=%b", st, op), 32'(got), 32'(e));
    @(posedge clk);
    #1;
  endtask

  // Expand an instruction into its cycle trace: fw fetch waits, mw data-memory waits.
  task automatic runInstr(input logic [5:0] op, input int fw, input int mw);
    stepT q[$];
    opCode = op;
    repeat (fw) q.push_back('{S_FETCH, 1'b0});
    q.push_back('{S_FETCH, 1'b1});
    q.push_back('{S_DECODE, 1'b0});
    case (op)
      OP_LW: begin
        q.push_back('{S_MEMADR, 1'b0});
        repeat (mw) q.push_back('{S_MEMRD, 1'b0});
        q.push_back('{S_MEMRD, 1'b1});
        q.push_back('{S_MEMWB, 1'b0});
      end
      OP_SW: begin
        q.push_back('{S_MEMADR, 1'b0});
        repeat (mw) q.push_back('{S_MEMWR, 1'b0});
        q.push_back('{S_MEMWR, 1'b1});
      end
      OP_RTYPE: begin
        q.push_back('{S_EXEC, 1'b0});
        q.push_back('{S_RTYPEWB, 1'b0});
      end
      OP_BEQ:  q.push_back('{S_BEQ, 1'b0});
      OP_J:    q.push_back('{S_JUMP, 1'b0});
      default: ;
    endcase
    foreach (q[i]) applyCycle(q[i].st, q[i].rdy, op, 1'b0);
  endtask

  initial begin
    logic [5:0] ops [5];
    logic [5:0] op;
    int         noWaitSeq [6];
    ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J};
    noWaitSeq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_FETCH};

    repeat (2) @(posedge clk);
    #1;
    applyCycle(S_FETCH, 1'b1, OP_LW, 1'b1);
    reset = 1'b0;

    runInstr(OP_LW, 0, 0);
    runInstr(OP_SW, 0, 2);
    runInstr(OP_RTYPE, 0, 0);
    runInstr(OP_BEQ, 0, 0);
    runInstr(OP_J, 0, 0);
    runInstr(OP_RTYPE, 3, 0);
    runInstr(6'b001000, 0, 0);

    // Reset for two cycles while a store waits in MEMWR.
    opCode = OP_SW;
    applyCycle(S_FETCH, 1'b1, OP_SW, 1'b0);
    applyCycle(S_DECODE, 1'b0, OP_SW, 1'b0);
    applyCycle(S_MEMADR, 1'b0, OP_SW, 1'b0);
    applyCycle(S_MEMWR, 1'b0, OP_SW, 1'b0);
    reset = 1'b1;
    applyCycle(S_MEMWR, 1'b0, OP_SW, 1'b1);
    applyCycle(S_FETCH, 1'b0, OP_SW, 1'b1);
    reset = 1'b0;

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        do op = 6'($urandom); while (op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J});
      end else begin
        op = ops[$urandom_range(0, 4)];
      end
      runInstr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Handshake disabled: lw must finish in 5 cycles with memReady stuck low.
    @(negedge clk);
    check("noWait reset state", 32'(state0), 32'(S_FETCH));
    check("noWait reset ctrl", 32'(got0), 32'd0);
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("noWait state cyc%0d", i), 32'(state0), 32'(noWaitSeq[i]));
      check($sformatf("noWait ctrl cyc%0d", i), 32'(got0), 32'(expOut(noWaitSeq[i], 1'b1, OP_LW)));
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
